// File: rtl/muldiv_iter.sv
// muldiv_iter -- iterative multiply/divide unit sitting beside the EX-stage ALU.
//
// Executes MULTU/MULT/DIVU/DIV on WIDTH-bit operands and returns a 2*WIDTH-bit
// {HI, LO} result through a start/ready handshake. Multiply is radix-2
// shift-add (LSB first), divide is restoring radix-2 (MSB first); signed ops
// run on magnitudes and get their signs fixed up in a final FIX cycle.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   defined   : multiplies use a single-cycle array product (IDLE -> DONE),
//               the shift-add datapath is not built.
//   undefined : multiplies iterate like divides.
//
// Ports:
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset
//   start_i     operation request, accepted only in IDLE
//   op_i        00 MULTU, 01 MULT, 10 DIVU, 11 DIV (sampled at accept)
//   opdata1_i   multiplicand / dividend (sampled at accept)
//   opdata2_i   multiplier / divisor (sampled at accept)
//   annul_i     abort the operation in flight (CALC/FIX), or drop a request
//   busy_o      high in CALC and FIX
//   ready_o     one-cycle pulse, result_o valid in the same cycle
//   result_o    multiply: full product; divide: {remainder, quotient}
//   div_zero_o  high with ready_o when a divide had a zero divisor
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div, s1, s2;
  // hi/lo double as accumulator {hi,lo} for multiply and as
  // {remainder, dividend-shifting-into-quotient} for divide.
  logic [WIDTH-1:0] hi, lo, opb;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic             accept, op_div, in_s1, in_s2, dz_req, short_op;
  logic [WIDTH-1:0] abs1, abs2;

  always_comb begin
    op_div   = op_i[1];
    in_s1    = op_i[0] & opdata1_i[WIDTH-1];
    in_s2    = op_i[0] & opdata2_i[WIDTH-1];
    abs1     = in_s1 ? -opdata1_i : opdata1_i;
    abs2     = in_s2 ? -opdata2_i : opdata2_i;
    accept   = (state == IDLE) & start_i & ~annul_i;
    dz_req   = op_div & (opdata2_i == '0);
`ifdef MULDIV_FAST_MUL_EN
    short_op = dz_req | ~op_div;
`else
    short_op = dz_req;
`endif
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign/zero-extend to 2*WIDTH so one signed multiplier serves both flavours.
  logic signed [2*WIDTH-1:0] ext1, ext2;
  logic        [2*WIDTH-1:0] fast_prod;

  always_comb begin
    ext1      = op_i[0] ? {{WIDTH{opdata1_i[WIDTH-1]}}, opdata1_i}
                        : {{WIDTH{1'b0}}, opdata1_i};
    ext2      = op_i[0] ? {{WIDTH{opdata2_i[WIDTH-1]}}, opdata2_i}
                        : {{WIDTH{1'b0}}, opdata2_i};
    fast_prod = ext1 * ext2;
  end
`endif

  // ---------------------------------------------------------------------
  // One CALC iteration
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   div_sh, div_diff;
  logic [WIDTH-1:0] hi_step, lo_step;
`ifndef MULDIV_FAST_MUL_EN
  logic [WIDTH:0]   mul_sum;
`endif

  always_comb begin
    // Restoring divide: bring in the next dividend bit, try the subtract,
    // keep it only when the WIDTH+1-bit difference is non-negative.
    div_sh   = {hi, lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opb};
    hi_step  = div_diff[WIDTH-1:0];
    lo_step  = {lo[WIDTH-2:0], 1'b1};
    if (div_diff[WIDTH]) begin
      hi_step = div_sh[WIDTH-1:0];
      lo_step = {lo[WIDTH-2:0], 1'b0};
    end
`ifndef MULDIV_FAST_MUL_EN
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    if (!is_div) begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo[WIDTH-1:1]};
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Sign fix-up (s1/s2 are already zero for unsigned ops)
  // ---------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_mag, fix_result;
  logic [WIDTH-1:0]   quot, rem;
  logic               neg_q;

  always_comb begin
    neg_q      = s1 ^ s2;
    prod_mag   = {hi, lo};
    quot       = neg_q ? -lo : lo;
    rem        = s1 ? -hi : hi;
    fix_result = is_div ? {rem, quot} : (neg_q ? -prod_mag : prod_mag);
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = short_op ? DONE : CALC;
      CALC: begin
        if (annul_i)              state_nxt = IDLE;
        else if (cnt == CW'(1))   state_nxt = FIX;
      end
      FIX:  state_nxt = annul_i ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      opb        <= '0;
      is_div     <= 1'b0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      result_o   <= '0;
      busy_o     <= 1'b0;
      ready_o    <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      busy_o     <= (state_nxt == CALC) | (state_nxt == FIX);
      ready_o    <= (state_nxt == DONE);
      // The only IDLE->DONE divide is the zero-divisor shortcut.
      div_zero_o <= accept & dz_req;
      case (state)
        IDLE: if (accept) begin
          is_div <= op_div;
          s1     <= in_s1;
          s2     <= in_s2;
          hi     <= '0;
          cnt    <= CW'(WIDTH);
          lo     <= op_div ? abs1 : abs2;
          opb    <= op_div ? abs2 : abs1;
          if (dz_req) result_o <= {opdata1_i, {WIDTH{1'b1}}};
`ifdef MULDIV_FAST_MUL_EN
          else if (!op_div) result_o <= fast_prod;
`endif
        end
        CALC: if (!annul_i) begin
          hi  <= hi_step;
          lo  <= lo_step;
          cnt <= cnt - CW'(1);
        end
        FIX: if (!annul_i) result_o <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter (WIDTH=32).
// A cycle-level behavioural model (plain 64-bit arithmetic plus expected
// busy window / ready cycle) is compared against the DUT on every cycle;
// directed cases additionally pin results and latencies to literals.
module tb_muldiv_iter;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic           clk = 0, resetn = 0, start_i = 0, annul_i = 0;
  logic [1:0]     op_i = '0;
  logic [W-1:0]   opdata1_i = '0, opdata2_i = '0;
  logic           busy_o, ready_o, div_zero_o;
  logic [2*W-1:0] result_o;

  muldiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o),
    .div_zero_o(div_zero_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;

  // model state, owned by the driver
  int          busy_lo = 1, busy_hi = 0, ready_at = 0, last_n = 0;
  bit          pend_valid = 0, pend_dz = 0;
  logic [63:0] pend_res = '0;
  // visible result register, owned by the compare process
  logic [63:0] vis_res = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // {div_zero, result} straight from the arithmetic definition
  function automatic logic [64:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint      sa, sb;
    logic [63:0] r;
    logic        dz;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    r  = '0;
    case (op)
      2'b00: r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      2'b01: r = sa * sb;
      2'b10: if (b == 0) begin dz = 1'b1; r = {a, {W{1'b1}}}; end
             else r = {a % b, a / b};
      default: if (b == 0) begin dz = 1'b1; r = {a, {W{1'b1}}}; end
               else r = {W'(sa % sb), W'(sa / sb)};
    endcase
    return {dz, r};
  endfunction

  function automatic int lat_of(input logic [1:0] op, input logic [W-1:0] b);
    if (op[1] && b == 0) return 1;
    if (!op[1] && FAST) return 1;
    return W + 2;
  endfunction

  // every cycle: compare DUT against the model
  always @(negedge clk) begin
    bit eb, er;
    if (!resetn) vis_res = '0;
    else if (pend_valid && cyc >= ready_at) vis_res = pend_res;
    eb = (cyc >= busy_lo) && (cyc <= busy_hi);
    er = pend_valid && (cyc == ready_at);
    chk("busy", busy_o, eb);
    chk("ready", ready_o, er);
    chk("div_zero", div_zero_o, er && pend_dz);
    chk("result", result_o, vis_res);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // drive a request for one cycle and tell the model it was accepted
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [64:0] m;
    int lat;
    op_i = op; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    m = model(op, a, b);
    lat = lat_of(op, b);
    last_n = cyc;
    pend_res = m[63:0];
    pend_dz = m[64];
    ready_at = cyc + lat;
    pend_valid = 1'b1;
    if (lat > 1) begin busy_lo = cyc + 1; busy_hi = cyc + W + 1; end
    else begin busy_lo = 1; busy_hi = 0; end
    step;
    start_i = 1'b0;
    op_i = 2'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
  endtask

  task automatic wait_ready(output int r_cyc, output logic [63:0] res, output logic dz);
    bit ok;
    ok = 0; r_cyc = -1; res = '0; dz = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready_o) begin
        ok = 1; r_cyc = cyc; res = result_o; dz = div_zero_o;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL ready_timeout: got no ready_o, expected one within 60 cycles of cycle %0d", last_n);
    end
    step;
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [63:0] er, input logic edz,
                          input int elat);
    int rc;
    logic [63:0] res;
    logic dz;
    issue(op, a, b);
    wait_ready(rc, res, dz);
    chk({name, "_result"}, res, er);
    chk({name, "_dz"}, dz, edz);
    chk({name, "_latency"}, rc - last_n, elat);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int mlat;
    int nr, rc, k;
    logic [63:0] res;
    logic dz;
    logic [1:0] op;
    logic [W-1:0] a, b;

    mlat = FAST ? 1 : W + 2;

    // reset state
    #1;
    chk("rst0_busy", busy_o, 0);
    chk("rst0_ready", ready_o, 0);
    chk("rst0_result", result_o, 0);
    chk("rst0_dz", div_zero_o, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    step;

    directed("divu_100_7", 2'b10, 100, 7, 64'h00000002_0000000E, 0, W + 2);
    directed("div_m7_2", 2'b11, 32'hFFFFFFF9, 2, 64'hFFFFFFFF_FFFFFFFD, 0, W + 2);
    directed("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0, W + 2);
    directed("mult", 2'b01, 32'hFFFFFFFF, 3, 64'hFFFFFFFF_FFFFFFFD, 0, mlat);
    directed("multu", 2'b00, 32'hFFFFFFFF, 3, 64'h00000002_FFFFFFFD, 0, mlat);
    directed("divu_5_0", 2'b10, 5, 0, 64'h00000005_FFFFFFFF, 1, 1);
    directed("divu_6_3", 2'b10, 6, 3, 64'h00000000_00000002, 0, W + 2);

    // annul in the 10th CALC cycle
    issue(2'b10, 1000, 3);
    repeat (9) step;
    annul_i = 1'b1; busy_hi = cyc; pend_valid = 0;
    step;
    annul_i = 1'b0;
    nr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) chk("annul_busy_low", busy_o, 0);
      if (ready_o) nr++;
    end
    chk("annul_no_ready", nr, 0);
    chk("annul_result_kept", result_o, 64'h00000000_00000002);
    step;
    directed("divu_9_2", 2'b10, 9, 2, 64'h00000001_00000004, 0, W + 2);

    // start together with annul in IDLE is dropped
    op_i = 2'b10; opdata1_i = 9; opdata2_i = 2; start_i = 1'b1; annul_i = 1'b1;
    step;
    start_i = 1'b0; annul_i = 1'b0;
    chk("idle_annul_busy", busy_o, 0);
    repeat (3) step;

    // asynchronous reset mid-CALC
    issue(2'b10, 1000, 3);
    repeat (4) step;
    #1 resetn = 1'b0;
    pend_valid = 0; busy_lo = 1; busy_hi = 0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_dz", div_zero_o, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    step;

    // start pulsed while busy is ignored
    issue(2'b10, 9, 2);
    repeat (3) step;
    op_i = 2'b00; opdata1_i = 7; opdata2_i = 7; start_i = 1'b1;
    step;
    start_i = 1'b0;
    wait_ready(rc, res, dz);
    chk("busy_start_result", res, 64'h00000001_00000004);
    chk("busy_start_latency", rc - last_n, W + 2);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      op = 2'($urandom);
      a = pick();
      b = pick();
      mlat = lat_of(op, b);
      k = $urandom_range(0, 9);
      issue(op, a, b);
      if (k == 0 && mlat > 1) begin
        k = $urandom_range(1, W + 1);
        repeat (k - 1) step;
        annul_i = 1'b1; busy_hi = cyc; pend_valid = 0;
        step;
        annul_i = 1'b0;
        step;
      end else if (k == 1 && mlat > 1) begin
        k = $urandom_range(1, mlat - 1);
        repeat (k - 1) step;
        op_i = 2'($urandom); opdata1_i = $urandom; opdata2_i = $urandom; start_i = 1'b1;
        step;
        start_i = 1'b0;
        wait_ready(rc, res, dz);
      end else if (k == 2) begin
        repeat (mlat - 1) step;
        annul_i = 1'b1;
        step;
        annul_i = 1'b0;
      end else begin
        wait_ready(rc, res, dz);
      end
    end

    repeat (2) step;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
